// File: rtl/blake2_g_pipe.sv
`default_nettype none
// ============================================================================
// Module      : blake2_g_pipe
// Description : BLAKE2b/BLAKE2s G-mixing unit with valid/ready handshake,
//               built as a bubble-collapsing pipeline or a two-cycle FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module blake2_g_pipe #(
    parameter int W         = 64,
    parameter int PIPELINES = 1,
    parameter int ITERATIVE = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_val,
    output logic         o_rdy,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_m0,
    input  logic [W-1:0] i_m1,
    output logic         o_val,
    input  logic         i_rdy,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic [W-1:0] o_c,
    output logic [W-1:0] o_d
);

    localparam int c_R1 = (W == 64) ? 32 : 16;
    localparam int c_R2 = (W == 64) ? 24 : 12;
    localparam int c_R3 = (W == 64) ? 16 : 8;
    localparam int c_R4 = (W == 64) ? 63 : 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX2 = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    if ((W != 32) && (W != 64)) begin : g_bad_width
        $error("blake2_g_pipe: W must be 32 or 64");
    end

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        return (x >> n) | (x << (W - n));
    endfunction

    // One half of G; result packed as {a, b, c, d}.
    function automatic logic [4*W-1:0] half_g(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic [W-1:0] d,
                                              input logic [W-1:0] m, input int ra, input int rb);
        logic [W-1:0] a1, b1, c1, d1;
        a1 = a + b + m;
        d1 = rotr(d ^ a1, ra);
        c1 = c + d1;
        b1 = rotr(b ^ c1, rb);
        return {a1, b1, c1, d1};
    endfunction

    if (ITERATIVE == 0) begin : g_pipe
        logic [4*W-1:0] w_h1;
        logic [4*W-1:0] w_g;

        assign w_h1 = half_g(i_a, i_b, i_c, i_d, i_m0, c_R1, c_R2);
        assign w_g  = half_g(w_h1[4*W-1:3*W], w_h1[3*W-1:2*W], w_h1[2*W-1:W], w_h1[W-1:0],
                             i_m1, c_R3, c_R4);

        if (PIPELINES == 0) begin : g_comb
            assign o_val = i_val;
            assign o_rdy = i_rdy;
            assign {o_a, o_b, o_c, o_d} = w_g;
        end else begin : g_regs
            logic [PIPELINES:1] r_v;
            logic [4*W-1:0]     r_data [1:PIPELINES];
            logic [PIPELINES:0] w_v_all;
            logic [4*W-1:0]     w_d_all [0:PIPELINES];
            logic [PIPELINES:1] w_ready;

            assign w_v_all = {r_v, i_val};

            always_comb begin
                w_d_all[0] = w_g;
                for (int k = 1; k <= PIPELINES; k++) begin
                    w_d_all[k] = r_data[k];
                end
            end

            // A stage may load if any stage from it to the output is empty or
            // the sink is taking the last word (unrolled ready chain).
            for (genvar k = 1; k <= PIPELINES; k++) begin : g_ready
                assign w_ready[k] = i_rdy || !(&r_v[PIPELINES:k]);
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_v <= '0;
                    for (int k = 1; k <= PIPELINES; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    for (int k = 1; k <= PIPELINES; k++) begin
                        if (w_ready[k]) begin
                            r_v[k] <= w_v_all[k-1];
                            if (w_v_all[k-1]) begin
                                r_data[k] <= w_d_all[k-1];
                            end
                        end
                    end
                end
            end

            assign o_rdy = w_ready[1];
            assign o_val = r_v[PIPELINES];
            assign {o_a, o_b, o_c, o_d} = r_data[PIPELINES];
        end
    end else begin : g_iter
        state_t         r_state;
        logic [W-1:0]   r_wa, r_wb, r_wc, r_wd, r_m1;
        logic [W-1:0]   r_oa, r_ob, r_oc, r_od;
        logic [4*W-1:0] w_h1;
        logic [4*W-1:0] w_h2;

        assign w_h1 = half_g(i_a, i_b, i_c, i_d, i_m0, c_R1, c_R2);
        assign w_h2 = half_g(r_wa, r_wb, r_wc, r_wd, r_m1, c_R3, c_R4);

        assign o_val = (r_state == S_OUT);
        assign o_rdy = (r_state == S_IDLE) || ((r_state == S_OUT) && i_rdy);
        assign {o_a, o_b, o_c, o_d} = {r_oa, r_ob, r_oc, r_od};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state <= S_IDLE;
                {r_wa, r_wb, r_wc, r_wd, r_m1} <= '0;
                {r_oa, r_ob, r_oc, r_od} <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_val) begin
                            {r_wa, r_wb, r_wc, r_wd} <= w_h1;
                            r_m1    <= i_m1;
                            r_state <= S_MIX2;
                        end
                    end
                    S_MIX2: begin
                        {r_oa, r_ob, r_oc, r_od} <= w_h2;
                        r_state <= S_OUT;
                    end
                    S_OUT: begin
                        // Output and next input can transfer in the same cycle.
                        if (i_rdy) begin
                            if (i_val) begin
                                {r_wa, r_wb, r_wc, r_wd} <= w_h1;
                                r_m1    <= i_m1;
                                r_state <= S_MIX2;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blake2_g_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_blake2_g_pipe
// Description : Self-checking bench: P=0..3 (W=64) and iterative (W=32) units.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blake2_g_pipe;

    typedef struct packed {
        logic [63:0] a, b, c, d;
    } res_t;

    typedef struct {
        int          inst;
        logic [63:0] a, b, c, d, m0, m1;
        int          lat;
        res_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic        v_in [5];
    logic        r_in [5];
    logic [63:0] ia [5], ib [5], ic [5], id [5], im0 [5], im1 [5];
    logic        oval [4], ordy [4];
    logic [63:0] oa [4], ob [4], oc [4], od [4];
    logic        it_val, it_rdy;
    logic [31:0] it_a, it_b, it_c, it_d;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out [5];
    res_t q [5][$];
    logic chk_stable [5];
    res_t held [5];
    vec_t tbl [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance g has PIPELINES = g; instance 4 is the iterative W=32 build.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        blake2_g_pipe #(.W(64), .PIPELINES(g), .ITERATIVE(0)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_val(v_in[g]), .o_rdy(ordy[g]),
            .i_a(ia[g]), .i_b(ib[g]), .i_c(ic[g]), .i_d(id[g]),
            .i_m0(im0[g]), .i_m1(im1[g]), .o_val(oval[g]), .i_rdy(r_in[g]),
            .o_a(oa[g]), .o_b(ob[g]), .o_c(oc[g]), .o_d(od[g])
        );
    end

    blake2_g_pipe #(.W(32), .PIPELINES(1), .ITERATIVE(1)) u_iter (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(v_in[4]), .o_rdy(it_rdy),
        .i_a(ia[4][31:0]), .i_b(ib[4][31:0]), .i_c(ic[4][31:0]), .i_d(id[4][31:0]),
        .i_m0(im0[4][31:0]), .i_m1(im1[4][31:0]), .o_val(it_val), .i_rdy(r_in[4]),
        .o_a(it_a), .o_b(it_b), .o_c(it_c), .o_d(it_d)
    );

    function automatic logic get_val(int i);
        if (i == 4) return it_val;
        return oval[i];
    endfunction

    function automatic logic get_rdy(int i);
        if (i == 4) return it_rdy;
        return ordy[i];
    endfunction

    function automatic res_t get_out(int i);
        if (i == 4) return {32'd0, it_a, 32'd0, it_b, 32'd0, it_c, 32'd0, it_d};
        return {oa[i], ob[i], oc[i], od[i]};
    endfunction

    function automatic logic [63:0] rot(logic [63:0] x, int n, int w, logic [63:0] mask);
        return ((x >> n) | (x << (w - n))) & mask;
    endfunction

    function automatic res_t gmodel(int w, logic [63:0] a, logic [63:0] b, logic [63:0] c,
                                    logic [63:0] d, logic [63:0] m0, logic [63:0] m1);
        logic [63:0] mask;
        int r1, r2, r3, r4;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (w == 64) begin r1 = 32; r2 = 24; r3 = 16; r4 = 63; end
        else         begin r1 = 16; r2 = 12; r3 = 8;  r4 = 7;  end
        a = a & mask; b = b & mask; c = c & mask; d = d & mask;
        a = (a + b + (m0 & mask)) & mask;
        d = rot(d ^ a, r1, w, mask);
        c = (c + d) & mask;
        b = rot(b ^ c, r2, w, mask);
        a = (a + b + (m1 & mask)) & mask;
        d = rot(d ^ a, r3, w, mask);
        c = (c + d) & mask;
        b = rot(b ^ c, r4, w, mask);
        return {a, b, c, d};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_res(string name, res_t act, res_t exp);
        check({name, "_a"}, act.a, exp.a);
        check({name, "_b"}, act.b, exp.b);
        check({name, "_c"}, act.c, exp.c);
        check({name, "_d"}, act.d, exp.d);
    endtask

    // Scoreboard: push on input transfer, pop on output transfer, and
    // require stable outputs across every stalled cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 5; i++) begin
                if (chk_stable[i]) check_res($sformatf("stall%0d", i), get_out(i), held[i]);
                if (v_in[i] && get_rdy(i))
                    q[i].push_back(gmodel((i == 4) ? 32 : 64, ia[i], ib[i], ic[i], id[i],
                                          im0[i], im1[i]));
                if (get_val(i) && r_in[i]) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("sb%0d_spurious", i), 64'd1, 64'd0);
                    end else begin
                        check_res($sformatf("sb%0d", i), get_out(i), q[i].pop_front());
                    end
                    n_out[i]++;
                end
                chk_stable[i] = (i != 0) && get_val(i) && !r_in[i];
                held[i] = get_out(i);
            end
        end
    end

    task automatic rand_in(int i);
        ia[i] = {$urandom, $urandom}; ib[i] = {$urandom, $urandom};
        ic[i] = {$urandom, $urandom}; id[i] = {$urandom, $urandom};
        im0[i] = {$urandom, $urandom}; im1[i] = {$urandom, $urandom};
    endtask

    task automatic drain();
        int c = 0;
        int pend;
        pend = q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size();
        while (pend != 0 && c < 40) begin
            @(negedge clk);
            c++;
            pend = q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size();
        end
        check("drain_pending", 64'(pend), 64'd0);
    endtask

    task automatic apply_directed(int t);
        int i;
        i = tbl[t].inst;
        @(posedge clk); #1;
        ia[i] = tbl[t].a; ib[i] = tbl[t].b; ic[i] = tbl[t].c; id[i] = tbl[t].d;
        im0[i] = tbl[t].m0; im1[i] = tbl[t].m1; r_in[i] = 1'b1; v_in[i] = 1'b1;
        for (int k = 0; k <= tbl[t].lat; k++) begin
            @(negedge clk);
            check($sformatf("dir%0d_val_c%0d", t, k), 64'(get_val(i)), 64'(k == tbl[t].lat));
            if (k == tbl[t].lat) check_res($sformatf("dir%0d", t), get_out(i), tbl[t].exp);
            if (i == 4 && k == 1) check("iter_rdy_mix2", 64'(get_rdy(i)), 64'd0);
            if (k < tbl[t].lat) begin
                @(posedge clk); #1;
                v_in[i] = 1'b0;
            end
        end
        @(posedge clk); #1;
        v_in[i] = 1'b0;
        drain();
    endtask

    task automatic run_stream(int i, int n);
        int  sent = 0;
        int  cyc = 0;
        int  base;
        logic acc;
        base = n_out[i];
        @(posedge clk); #1;
        while (n_out[i] < base + n && cyc < 3000) begin
            r_in[i] = ($urandom_range(0, 3) != 0);
            if (!v_in[i] && sent < n && $urandom_range(0, 2) != 0) begin
                rand_in(i);
                v_in[i] = 1'b1;
            end
            @(negedge clk);
            acc = v_in[i] && get_rdy(i);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                v_in[i] = 1'b0;
            end
        end
        v_in[i] = 1'b0;
        r_in[i] = 1'b1;
        check($sformatf("stream%0d_count", i), 64'(n_out[i] - base), 64'(n));
        check($sformatf("stream%0d_left", i), 64'(q[i].size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_t ones;
        ones = {64'h0000_0000_0000_0101, 64'h0202_0002_0002_0200,
                64'h0101_0001_0001_0000, 64'h0101_0000_0001_0000};
        tbl[0] = '{1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1, '0};
        tbl[1] = '{2, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2, ones};
        tbl[2] = '{4, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2,
                   {64'h11, 64'h2022_0202, 64'h1101_0100, 64'h1100_0100}};
        tbl[3] = '{3, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 3, ones};
        tbl[4] = '{0, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, ones};

        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v_in[i] = 1'b0; r_in[i] = 1'b1; n_out[i] = 0; chk_stable[i] = 1'b0;
            ia[i] = '0; ib[i] = '0; ic[i] = '0; id[i] = '0; im0[i] = '0; im1[i] = '0;
        end

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst%0d_val", i), 64'(get_val(i)), 64'd0);
            check($sformatf("rst%0d_rdy", i), 64'(get_rdy(i)), 64'd1);
            if (i != 0) check_res($sformatf("rst%0d", i), get_out(i), '0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) apply_directed(t);

        run_stream(3, 20);
        run_stream(4, 12);
        drain();

        // Fill P=2 with the sink stalled, then release sink and source together.
        @(posedge clk); #1;
        r_in[2] = 1'b0; rand_in(2); v_in[2] = 1'b1;
        @(negedge clk); check("fill_rdy_0", 64'(ordy[2]), 64'd1);
        @(posedge clk); #1; rand_in(2);
        @(negedge clk); check("fill_rdy_1", 64'(ordy[2]), 64'd1);
        @(posedge clk); #1; rand_in(2);
        @(negedge clk);
        check("full_rdy", 64'(ordy[2]), 64'd0);
        check("full_val", 64'(oval[2]), 64'd1);
        @(posedge clk); #1;
        r_in[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("flow_rdy_%0d", j), 64'(ordy[2]), 64'd1);
            check($sformatf("flow_val_%0d", j), 64'(oval[2]), 64'd1);
            @(posedge clk); #1;
            rand_in(2);
        end
        v_in[2] = 1'b0;
        drain();

        // Asynchronous reset between clock edges with words in flight.
        @(posedge clk); #1;
        for (int i = 1; i < 5; i++) begin rand_in(i); v_in[i] = 1'b1; end
        repeat (2) begin
            @(posedge clk); #1;
            for (int i = 1; i < 5; i++) rand_in(i);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) v_in[i] = 1'b0;
        #1;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("arst%0d_val", i), 64'(get_val(i)), 64'd0);
            check($sformatf("arst%0d_rdy", i), 64'(get_rdy(i)), 64'd1);
            check_res($sformatf("arst%0d", i), get_out(i), '0);
        end
        for (int i = 0; i < 5; i++) begin q[i].delete(); chk_stable[i] = 1'b0; end
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) apply_directed(t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
